// File: rtl/ddr_port0_frame_writer_pkg.sv
// Shared definitions for the DDR frame-buffer writer/reader pair: resolution switch
// codes, per-mode pixel counts, MIG command encodings and the writer FSM states.
package ddr_port0_frame_writer_pkg;

  localparam int PIX_W  = 21;
  localparam int BLEN_W = 7;

  localparam logic [3:0] RES_VGA  = 4'b0000;
  localparam logic [3:0] RES_SVGA = 4'b0001;
  localparam logic [3:0] RES_720P = 4'b0010;
  localparam logic [3:0] RES_XGA  = 4'b0011;

  localparam logic [PIX_W-1:0] PIX_VGA  = 21'd307200;
  localparam logic [PIX_W-1:0] PIX_SVGA = 21'd480000;
  localparam logic [PIX_W-1:0] PIX_XGA  = 21'd786432;
  localparam logic [PIX_W-1:0] PIX_720P = 21'd921600;
  localparam logic [PIX_W-1:0] PIX_SXGA = 21'd1310720;

  localparam logic [2:0] MIG_CMD_WR = 3'b000;
  localparam logic [2:0] MIG_CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_CALIB,
    ST_FILL,
    ST_CMD,
    ST_DRAIN
  } wr_state_e;

  // Words in the next burst: the full burst size, or whatever is left of the frame.
  function automatic logic [BLEN_W-1:0] burst_words(input logic [PIX_W-1:0]  remain,
                                                    input logic [BLEN_W-1:0] burst);
    if (remain < PIX_W'(burst)) return remain[BLEN_W-1:0];
    return burst;
  endfunction

endpackage

// File: rtl/ddr_port0_frame_writer_res_pixel_lut.sv
// Resolution switch to frame pixel count; shared by the frame writer and reader.
module res_pixel_lut
  import ddr_port0_frame_writer_pkg::*;
(
  input  logic [3:0]       res_i,
  output logic [PIX_W-1:0] pixels_o
);

  // Unlisted switch codes fall back to the largest mode (SXGA)
  always_comb begin
    pixels_o = PIX_SXGA;
    case (res_i)
      RES_VGA:  pixels_o = PIX_VGA;
      RES_SVGA: pixels_o = PIX_SVGA;
      RES_XGA:  pixels_o = PIX_XGA;
      RES_720P: pixels_o = PIX_720P;
      default:  pixels_o = PIX_SXGA;
    endcase
  end

endmodule

// File: rtl/ddr_port0_frame_writer.sv
// Packs coloured pixels into the MIG port-0 write FIFO and issues one write command per
// burst, walking a linear frame buffer that wraps back to BASE_ADDR after each frame.
module ddr_port0_frame_writer
  import ddr_port0_frame_writer_pkg::*;
#(
  parameter int          BURST          = 64,
  parameter logic [29:0] BASE_ADDR      = 30'd0,
  parameter int          TOTAL_OVERRIDE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic [3:0]  resolution,
  input  logic        update,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  output logic        wr_en,
  input  logic        wr_full,
  input  logic        wr_empty,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  output logic        cmd_en,
  input  logic        cmd_full,
  output logic        frame_done
);

  logic [PIX_W-1:0]  lut_pixels;
  logic [PIX_W-1:0]  total_src;

  logic              calib_s1_q, calib_s2_q;
  wr_state_e         state_q, state_d;
  logic [PIX_W-1:0]  index_q, index_d;
  logic [PIX_W-1:0]  total_q, total_d;
  logic [BLEN_W-1:0] fill_q, fill_d;
  logic [BLEN_W-1:0] blen_q, blen_d;
  logic              upd_pend_q, upd_pend_d;
  logic              cmd_en_q, cmd_en_d;
  logic [2:0]        cmd_instr_q, cmd_instr_d;
  logic [5:0]        cmd_bl_q, cmd_bl_d;
  logic [29:0]       cmd_addr_q, cmd_addr_d;
  logic              frame_done_q, frame_done_d;
  logic              accept;

  res_pixel_lut u_lut (
    .res_i    (resolution),
    .pixels_o (lut_pixels)
  );

  // A nonzero override shortens the frame so a whole frame fits in a short simulation
  assign total_src = (TOTAL_OVERRIDE != 0) ? PIX_W'(TOTAL_OVERRIDE) : lut_pixels;

  // Pixels go straight to the MIG FIFO with no added latency
  assign pix_ready     = (state_q == ST_FILL) && !wr_full && (fill_q < blen_q);
  assign accept        = pix_valid && pix_ready;
  assign wr_en         = accept;
  assign wr_data       = {8'h00, pix_data};
  assign wr_mask       = 4'b0000;
  assign cmd_en        = cmd_en_q;
  assign cmd_instr     = cmd_instr_q;
  assign cmd_bl        = cmd_bl_q;
  assign cmd_byte_addr = cmd_addr_q;
  assign frame_done    = frame_done_q;

  // Next-state logic: burst fill, command issue, FIFO drain and pending-update handling
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    total_d      = total_q;
    fill_d       = fill_q;
    blen_d       = blen_q;
    upd_pend_d   = upd_pend_q;
    cmd_en_d     = 1'b0;
    cmd_instr_d  = cmd_instr_q;
    cmd_bl_d     = cmd_bl_q;
    cmd_addr_d   = cmd_addr_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_CALIB: begin
        // Nothing is in flight yet, so an update takes effect at once
        upd_pend_d = 1'b0;
        if (update || upd_pend_q) begin
          total_d = total_src;
          index_d = '0;
        end
        if (calib_s2_q) begin
          state_d = ST_FILL;
          fill_d  = '0;
          blen_d  = burst_words(total_d - index_d, BLEN_W'(BURST));
        end
      end
      ST_FILL: begin
        if (update) upd_pend_d = 1'b1;
        if (accept) fill_d = fill_q + 1'b1;
        if (fill_d == blen_q) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (update) upd_pend_d = 1'b1;
        if (!cmd_full) begin
          cmd_en_d    = 1'b1;
          cmd_instr_d = MIG_CMD_WR;
          cmd_bl_d    = 6'(blen_q - 1'b1);
          cmd_addr_d  = BASE_ADDR + 30'({index_q, 2'b00});
          if (index_q + PIX_W'(blen_q) == total_q) begin
            index_d      = '0;
            frame_done_d = 1'b1;
          end else begin
            index_d = index_q + PIX_W'(blen_q);
          end
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (update) upd_pend_d = 1'b1;
        if (wr_empty) begin
          // The in-flight burst is done; a pending update restarts the frame here, once
          if (upd_pend_q || update) begin
            total_d    = total_src;
            index_d    = '0;
            upd_pend_d = 1'b0;
          end
          state_d = ST_FILL;
          fill_d  = '0;
          blen_d  = burst_words(total_d - index_d, BLEN_W'(BURST));
        end
      end
      default: state_d = ST_CALIB;
    endcase
  end

  // State, counters, command registers and the calibration synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      calib_s1_q   <= 1'b0;
      calib_s2_q   <= 1'b0;
      state_q      <= ST_CALIB;
      index_q      <= '0;
      total_q      <= total_src;
      fill_q       <= '0;
      blen_q       <= '0;
      upd_pend_q   <= 1'b0;
      cmd_en_q     <= 1'b0;
      cmd_instr_q  <= 3'b000;
      cmd_bl_q     <= '0;
      cmd_addr_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      calib_s1_q   <= mem_calib_done;
      calib_s2_q   <= calib_s1_q;
      state_q      <= state_d;
      index_q      <= index_d;
      total_q      <= total_d;
      fill_q       <= fill_d;
      blen_q       <= blen_d;
      upd_pend_q   <= upd_pend_d;
      cmd_en_q     <= cmd_en_d;
      cmd_instr_q  <= cmd_instr_d;
      cmd_bl_q     <= cmd_bl_d;
      cmd_addr_q   <= cmd_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
